// File: rtl/ram_clr_if.sv
// ram_clr_if: data-path bundle for the self-clearing RAM.
// Handshake: the master may present load/sel/in every cycle, but a write is
// taken only on a rising edge where ready=1 and clear=0. While ready=0, the
// RAM ignores load and drives out=0. clear is taken on any rising edge and
// takes priority over load.
interface ram_clr_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12
);
    logic [WIDTH-1:0]  in;
    logic              load;
    logic [ADDR_W-1:0] sel;
    logic              clear;
    logic [WIDTH-1:0]  out;
    logic              ready;
    logic              dbg_state;   // 0 = sweeping, 1 = usable

    modport master (
        output in, load, sel, clear,
        input  out, ready, dbg_state
    );

    modport slave (
        input  in, load, sel, clear,
        output out, ready, dbg_state
    );
endinterface

// File: rtl/ram_clr.sv
// ram_clr: word-addressed RAM with a built-in clear sweep.
// After reset, or on a clear request, every word is written with CLEAR_VAL,
// one word per clock. Reads and writes are blocked until the sweep finishes.
// The storage array has no reset; only the sequencer state does.
module ram_clr #(
    parameter int               WIDTH     = 16,
    parameter int               ADDR_W    = 12,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic       clk,
    input  logic       reset,
    ram_clr_if.slave   bus
);
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [WIDTH-1:0]  w_wdata;

    logic [WIDTH-1:0]  r_mem [DEPTH];

    // Sequencer state and sweep counter; reset forces a fresh sweep at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and the single write port's controls; clear beats load.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_waddr     = bus.sel;
        w_wdata     = bus.in;
        if (bus.clear) begin
            // The clear edge itself writes nothing; address 0 goes next edge.
            w_state_nxt = ST_CLEAR;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    w_we    = 1'b1;
                    w_waddr = r_cnt;
                    w_wdata = CLEAR_VAL;
                    if (r_cnt == LAST_ADDR) begin
                        w_state_nxt = ST_READY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    w_we = bus.load;
                end
                default: begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Storage write; suppressed while reset is held so no edge lands mid-reset.
    always_ff @(posedge clk) begin
        if (w_we && !reset) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Read is combinational but masked to zero until the sweep has completed.
    assign bus.out       = (r_state == ST_READY) ? r_mem[bus.sel] : '0;
    assign bus.ready     = (r_state == ST_READY);
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ram_clr.sv
// tb_ram_clr: bench for ram_clr at three parameter sets
// (ADDR_W=4; default 16x4K; ADDR_W=3 with CLEAR_VAL=16'hFFFF).
module tb_ram_clr;
    logic clk;
    logic rst_a, rst_b, rst_c;
    int   n_tests;
    int   n_fail;

    ram_clr_if #(.WIDTH(16), .ADDR_W(4))  bus_a ();
    ram_clr_if #(.WIDTH(16), .ADDR_W(12)) bus_b ();
    ram_clr_if #(.WIDTH(16), .ADDR_W(3))  bus_c ();

    ram_clr #(.WIDTH(16), .ADDR_W(4)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a)
    );
    ram_clr dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b)
    );
    ram_clr #(.WIDTH(16), .ADDR_W(3), .CLEAR_VAL(16'hFFFF)) dut_c (
        .clk(clk), .reset(rst_c), .bus(bus_c)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        load;
        logic [3:0]  sel;
        logic [15:0] din;
        logic        clear;
        logic        exp_ready;
        logic [15:0] exp_out;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] exp_q [$];
    logic [15:0] m_mem [16];
    int          m_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Counts rising edges until the chosen instance reports ready (bounded).
    task automatic wait_ready(input int which, input int budget, output int n);
        logic r;
        n = 0;
        r = 1'b0;
        while (!r && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            case (which)
                0:       r = bus_a.ready;
                1:       r = bus_b.ready;
                default: r = bus_c.ready;
            endcase
        end
    endtask

    task automatic drive_a(input logic ld, input logic [3:0] s, input logic [15:0] d, input logic cl);
        bus_a.load  = ld;
        bus_a.sel   = s;
        bus_a.in    = d;
        bus_a.clear = cl;
    endtask

    initial begin
        int n;
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{1'b1, 4'd2,  16'h1111, 1'b0, 1'b1, 16'h1111};
        vecs[1] = '{1'b0, 4'd2,  16'h2222, 1'b0, 1'b1, 16'h1111};
        vecs[2] = '{1'b1, 4'd15, 16'hABCD, 1'b0, 1'b1, 16'hABCD};
        vecs[3] = '{1'b0, 4'd14, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vecs[4] = '{1'b1, 4'd0,  16'hFFFF, 1'b0, 1'b1, 16'hFFFF};
        vecs[5] = '{1'b0, 4'd15, 16'h0000, 1'b0, 1'b1, 16'hABCD};
        vecs[6] = '{1'b0, 4'd2,  16'h0000, 1'b0, 1'b1, 16'h1111};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        drive_a(1'b1, 4'd3, 16'hBEEF, 1'b0);
        bus_b.load = 1'b0; bus_b.sel = '0; bus_b.in = '0; bus_b.clear = 1'b0;
        bus_c.load = 1'b0; bus_c.sel = '0; bus_c.in = '0; bus_c.clear = 1'b0;

        @(posedge clk); #1;
        check("reset_ready_a", {31'd0, bus_a.ready}, 32'd0);
        check("reset_out_a", {16'd0, bus_a.out}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;

        // Sweep with load held high: out stays 0 and the write is dropped.
        n = 0;
        while (!bus_a.ready && n < 40) begin
            @(posedge clk); #1; n++;
            if (!bus_a.ready) check("sweep_out_zero", {16'd0, bus_a.out}, 32'd0);
        end
        check("sweep_len_a", n, 16);
        drive_a(1'b0, 4'd0, 16'h0000, 1'b0);
        for (int a = 0; a < 16; a++) begin
            bus_a.sel = a[3:0];
            #1;
            check("swept_zero_a", {16'd0, bus_a.out}, 32'd0);
        end

        // Table-driven write/read vectors, one edge each.
        for (int i = 0; i < 7; i++) begin
            drive_a(vecs[i].load, vecs[i].sel, vecs[i].din, vecs[i].clear);
            @(posedge clk); #1;
            check("vec_ready", {31'd0, bus_a.ready}, {31'd0, vecs[i].exp_ready});
            check("vec_out", {16'd0, bus_a.out}, {16'd0, vecs[i].exp_out});
        end

        // Clear beats load on the same edge.
        drive_a(1'b1, 4'd5, 16'hAAAA, 1'b0);
        @(posedge clk); #1;
        check("write_aaaa", {16'd0, bus_a.out}, 32'h0000AAAA);
        drive_a(1'b1, 4'd6, 16'h5555, 1'b1);
        @(posedge clk); #1;
        check("clear_edge_ready", {31'd0, bus_a.ready}, 32'd0);
        drive_a(1'b0, 4'd6, 16'h0000, 1'b0);
        wait_ready(0, 40, n);
        check("clear_sweep_len", n, 16);
        check("clear_addr6", {16'd0, bus_a.out}, 32'd0);
        bus_a.sel = 4'd5; #1;
        check("clear_addr5", {16'd0, bus_a.out}, 32'd0);

        // Asynchronous reset while in use: out and ready drop without an edge.
        drive_a(1'b1, 4'd9, 16'h7777, 1'b0);
        @(posedge clk); #1;
        drive_a(1'b0, 4'd9, 16'h0000, 1'b0);
        check("write_7777", {16'd0, bus_a.out}, 32'h00007777);
        #2; rst_a = 1'b1; #1;
        check("async_rst_ready", {31'd0, bus_a.ready}, 32'd0);
        check("async_rst_out", {16'd0, bus_a.out}, 32'd0);
        @(negedge clk); rst_a = 1'b0;
        wait_ready(0, 40, n);
        check("post_rst_sweep", n, 16);

        // Reset after 7 sweep edges restarts the full sweep.
        drive_a(1'b0, 4'd9, 16'h0000, 1'b1);
        @(posedge clk); #1;
        bus_a.clear = 1'b0;
        repeat (7) @(posedge clk);
        #2; rst_a = 1'b1; #1;
        check("midsweep_rst_ready", {31'd0, bus_a.ready}, 32'd0);
        @(negedge clk); rst_a = 1'b0;
        wait_ready(0, 40, n);
        check("midsweep_full_len", n, 16);

        // Randomised traffic against an array model of the RAM.
        for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
        m_left = 0;
        for (int i = 0; i < 250; i++) begin
            logic       ld, cl;
            logic [3:0] s;
            logic [15:0] d;
            ld = 1'($urandom_range(0, 1));
            cl = (i == 0) || ($urandom_range(0, 29) == 0);
            s  = 4'($urandom_range(0, 15));
            d  = 16'($urandom);
            drive_a(ld, s, d, cl);
            @(posedge clk);
            if (cl) begin
                m_left = 16;
            end else if (m_left > 0) begin
                m_mem[16 - m_left] = 16'h0000;
                m_left--;
            end else if (ld) begin
                m_mem[s] = d;
            end
            exp_q.push_back((m_left == 0) ? m_mem[s] : 16'h0000);
            #1;
            check("rand_out", {16'd0, bus_a.out}, {16'd0, exp_q.pop_front()});
            check("rand_ready", {31'd0, bus_a.ready}, {31'd0, (m_left == 0)});
        end
        drive_a(1'b0, 4'd0, 16'h0000, 1'b0);

        // Default geometry: 4096-edge sweep, then write/read.
        @(negedge clk); rst_b = 1'b0;
        wait_ready(1, 5000, n);
        check("sweep_len_b", n, 4096);
        bus_b.in = 16'hF00D; bus_b.sel = 12'b100101011000; bus_b.load = 1'b1;
        @(posedge clk); #1;
        check("b_write", {16'd0, bus_b.out}, 32'h0000F00D);
        bus_b.load = 1'b0; bus_b.in = 16'h1234;
        @(posedge clk); #1;
        check("b_hold", {16'd0, bus_b.out}, 32'h0000F00D);
        bus_b.sel = 12'b100101011001; #1;
        check("b_neighbour", {16'd0, bus_b.out}, 32'd0);

        // Non-zero clear value.
        @(negedge clk); rst_c = 1'b0;
        wait_ready(2, 20, n);
        check("sweep_len_c", n, 8);
        for (int a = 0; a < 8; a++) begin
            bus_c.sel = a[2:0]; #1;
            check("c_clearval", {16'd0, bus_c.out}, 32'h0000FFFF);
        end
        bus_c.sel = 3'd2; bus_c.in = 16'h0001; bus_c.load = 1'b1;
        @(posedge clk); #1;
        check("c_write", {16'd0, bus_c.out}, 32'h00000001);
        bus_c.load = 1'b0; bus_c.clear = 1'b1;
        @(posedge clk); #1;
        bus_c.clear = 1'b0;
        wait_ready(2, 20, n);
        check("c_clear_len", n, 8);
        check("c_recleared", {16'd0, bus_c.out}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
